rank_writeback: RTL and testbench
=================================

RANK_WRITEBACK -- requirements
Module: rank_writeback

Interface
REQ-001 MAX_OUTSTANDING, 4, maximum AXI write transactions awaiting B response (1..15).
REQ-002 AWID, 16'h0002, constant ID driven on awid.
REQ-003 clk  in  1  clock; all logic rising-edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 start  in  1  one-cycle pulse; latches base_addr and n_values, begins job.
REQ-006 base_addr  in  64  byte address of output rank array; bits [5:0] ignored (forced 0).
REQ-007 n_values  in  64  number of 64-bit rank values in job.
REQ-008 in_valid  in  1  rank value offered.
REQ-009 in_data  in  64  rank value.
REQ-010 in_ready  out  1  value accepted when in_valid and in_ready both high.
REQ-011 awid  out  16  always AWID.
REQ-012 awaddr  out  64  beat address.
REQ-013 awlen  out  8  always 0.
REQ-014 awsize  out  3  always 3'b110.
REQ-015 awvalid  out  1  write address valid.
REQ-016 awready  in  1  write address accepted.
REQ-017 wdata  out  512  packed beat.
REQ-018 wstrb  out  64  byte strobes.
REQ-019 wlast  out  1  high whenever wvalid high.
REQ-020 wvalid  out  1  write data valid.
REQ-021 wready  in  1  write data accepted.
REQ-022 bresp  in  2  write response code.
REQ-023 bvalid  in  1  write response valid.
REQ-024 bready  out  1  constant 1 outside reset.
REQ-025 busy  out  1  high from start acceptance until done pulse.
REQ-026 done  out  1  one-cycle pulse: all values written and all B responses received.
REQ-027 err_count  out  16  count of B responses with bresp != 0 (see REQ-041).

Function
REQ-028 States IDLE, FILL, ISSUE, DRAIN, DONE; start honoured only in IDLE, ignored otherwise.
REQ-029 IDLE+start: n_values==0 -> DONE next cycle, no transactions; else -> FILL with lane=0, beat=0.
REQ-030 in_ready = (state==FILL); one value per cycle; value j of beat placed at wdata[511-64j -: 64] (lane 0 in [511:448]).
REQ-031 FILL -> ISSUE on the cycle the 8th lane or the job's final value is accepted.
REQ-032 ISSUE: awaddr = base_addr + 64*beat; wstrb = all ones for full beat, else top 8*m bits set for m valid lanes, unused lanes zero.
REQ-033 awvalid and wvalid rise together, only if outstanding < MAX_OUTSTANDING; each falls independently the cycle after its own handshake; payload stable while valid.
REQ-034 When both handshakes done: beat+1; -> FILL if values remain, else -> DRAIN.
REQ-035 outstanding counter: +1 on AW handshake, -1 on bvalid; simultaneous -> unchanged; never wraps.
REQ-036 DRAIN -> DONE when outstanding==0; DONE asserts done one cycle, -> IDLE; busy low in IDLE.
REQ-037 bvalid with outstanding==0 is ignored (no decrement, no err count).

Reset
REQ-038 rst: state IDLE, counters 0, awvalid/wvalid/in_ready/busy/done/err_count 0, wdata/awaddr/wstrb 0; rst mid-job abandons job, including an in-flight handshake.
REQ-039 bready 0 during rst cycle, 1 thereafter.

Configuration
REQ-040 Macro RANK_WB_ERRCNT_EN selects error counting.
REQ-041 Defined: err_count +1 per accepted B with bresp!=0, saturating at 16'hFFFF, cleared on start; undefined: err_count constant 0, no counter logic.

Verification
REQ-042 base_addr=0x1000, n_values=8, values 1..8, ready always -> one AW 0x1000, wdata[511:448]=1, [63:0]=8, wstrb all ones, done after B.
REQ-043 n_values=10 -> beats at base, base+64; second wstrb=64'hFFFF000000000000, lanes 2..7 zero.
REQ-044 n_values=0 -> done one cycle after start, awvalid never high.
REQ-045 MAX_OUTSTANDING=4, bvalid held 0, n_values=48 -> exactly 4 AW handshakes, then awvalid low; releasing bvalid completes 6 beats and done.
REQ-046 awready low 5 cycles, wready high -> wvalid drops after 1 cycle, awvalid holds; with RANK_WB_ERRCNT_EN, bresp=2 on both beats of REQ-043 -> err_count=2.

Source files
------------

// File: rtl/rank_writeback_if.sv
// AXI4 write-channel bundle (AW/W/B) for the rank writeback engine.
// The engine is master; memory or a bench model is slave.
interface rank_writeback_if;
  logic [15:0]  awid;
  logic [63:0]  awaddr;
  logic [7:0]   awlen;
  logic [2:0]   awsize;
  logic         awvalid;
  logic         awready;
  logic [511:0] wdata;
  logic [63:0]  wstrb;
  logic         wlast;
  logic         wvalid;
  logic         wready;
  logic [1:0]   bresp;
  logic         bvalid;
  logic         bready;

  modport master (
    output awid, awaddr, awlen, awsize, awvalid,
    output wdata, wstrb, wlast, wvalid,
    output bready,
    input  awready, wready, bresp, bvalid
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awvalid,
    input  wdata, wstrb, wlast, wvalid,
    input  bready,
    output awready, wready, bresp, bvalid
  );
endinterface

// File: rtl/rank_writeback.sv
// Packs 64-bit rank values into 512-bit beats and writes them over AXI.
// Optional B-error counter enabled by defining RANK_WB_ERRCNT_EN.
module rank_writeback #(
  parameter int          MAX_OUTSTANDING = 4,
  parameter logic [15:0] AWID            = 16'h0002
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [63:0] base_addr,
  input  logic [63:0] n_values,
  input  logic        in_valid,
  input  logic [63:0] in_data,
  output logic        in_ready,
  rank_writeback_if.master axi,
  output logic        busy,
  output logic        done,
  output logic [15:0] err_count
);

  typedef enum logic [2:0] {
    IDLE, FILL, ISSUE, DRAIN, DONE
  } state_t;

  state_t state_q, state_d;

  logic [63:0]  base_q;
  logic [63:0]  remaining_q;
  logic [2:0]   lane_q;
  logic [57:0]  beat_q;
  logic [3:0]   outstanding_q;
  logic [511:0] wdata_q;
  logic [63:0]  wstrb_q;
  logic [63:0]  awaddr_q;
  logic         awvalid_q;
  logic         wvalid_q;
  logic         issued_q;
  logic         aw_done_q;
  logic         w_done_q;

  logic acc, aw_hs, w_hs, b_take;
  logic both_done, can_issue;

  assign acc       = in_valid & in_ready;
  assign aw_hs     = awvalid_q & axi.awready;
  assign w_hs      = wvalid_q & axi.wready;
  assign b_take    = axi.bvalid & axi.bready
                   & (outstanding_q != 4'd0);
  assign both_done = issued_q
                   & (aw_done_q | aw_hs)
                   & (w_done_q | w_hs);
  assign can_issue = !issued_q
                   && (outstanding_q < 4'(MAX_OUTSTANDING));

  assign in_ready = ~rst & (state_q == FILL);
  assign busy     = ~rst & (state_q != IDLE);
  assign done     = ~rst & (state_q == DONE);

  assign axi.awid    = AWID;
  assign axi.awaddr  = awaddr_q;
  assign axi.awlen   = 8'd0;
  assign axi.awsize  = 3'b110;
  assign axi.awvalid = awvalid_q;
  assign axi.wdata   = wdata_q;
  assign axi.wstrb   = wstrb_q;
  assign axi.wvalid  = wvalid_q;
  assign axi.wlast   = wvalid_q;
  assign axi.bready  = ~rst;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:
        if (start)
          state_d = (n_values == 64'd0) ? DONE : FILL;
      FILL:
        if (acc && (lane_q == 3'd7
                    || remaining_q == 64'd1))
          state_d = ISSUE;
      ISSUE:
        if (both_done)
          state_d = (remaining_q != 64'd0) ? FILL : DRAIN;
      DRAIN:
        if (outstanding_q == 4'd0) state_d = DONE;
      DONE:
        state_d = IDLE;
      default:
        state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      base_q        <= '0;
      remaining_q   <= '0;
      lane_q        <= '0;
      beat_q        <= '0;
      outstanding_q <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      awaddr_q      <= '0;
      awvalid_q     <= 1'b0;
      wvalid_q      <= 1'b0;
      issued_q      <= 1'b0;
      aw_done_q     <= 1'b0;
      w_done_q      <= 1'b0;
    end else begin
      if (aw_hs) begin
        awvalid_q <= 1'b0;
        aw_done_q <= 1'b1;
      end
      if (w_hs) begin
        wvalid_q <= 1'b0;
        w_done_q <= 1'b1;
      end

      if (state_q == IDLE && start) begin
        base_q      <= {base_addr[63:6], 6'b0};
        remaining_q <= n_values;
        lane_q      <= '0;
        beat_q      <= '0;
        wdata_q     <= '0;
        wstrb_q     <= '0;
        issued_q    <= 1'b0;
        aw_done_q   <= 1'b0;
        w_done_q    <= 1'b0;
      end

      if (state_q == FILL && acc) begin
        for (int i = 0; i < 8; i++) begin
          if (lane_q == 3'(i)) begin
            wdata_q[511-64*i -: 64] <= in_data;
            wstrb_q[63-8*i -: 8]    <= 8'hFF;
          end
        end
        remaining_q <= remaining_q - 64'd1;
        lane_q      <= lane_q + 3'd1;
        awaddr_q    <= base_q + {beat_q, 6'b0};
      end

      if (state_q == ISSUE) begin
        if (can_issue) begin
          awvalid_q <= 1'b1;
          wvalid_q  <= 1'b1;
          issued_q  <= 1'b1;
        end
        // Payload is cleared only after both channels have let go of it.
        if (both_done) begin
          beat_q    <= beat_q + 58'd1;
          lane_q    <= '0;
          wdata_q   <= '0;
          wstrb_q   <= '0;
          issued_q  <= 1'b0;
          aw_done_q <= 1'b0;
          w_done_q  <= 1'b0;
        end
      end

      if (aw_hs && !b_take)
        outstanding_q <= outstanding_q + 4'd1;
      else if (!aw_hs && b_take)
        outstanding_q <= outstanding_q - 4'd1;
    end
  end

`ifdef RANK_WB_ERRCNT_EN
  logic [15:0] err_q;
  logic        unused_bits;

  assign unused_bits = ^base_addr[5:0];

  always_ff @(posedge clk) begin
    if (rst)
      err_q <= '0;
    else if (state_q == IDLE && start)
      err_q <= '0;
    else if (b_take && axi.bresp != 2'b00
             && err_q != 16'hFFFF)
      err_q <= err_q + 16'd1;
  end

  assign err_count = err_q;
`else
  logic unused_bits;

  assign unused_bits = ^{base_addr[5:0], axi.bresp};
  assign err_count   = 16'd0;
`endif

endmodule

// File: tb/tb_rank_writeback.sv
// Scoreboard bench for rank_writeback: expected beats are queued by
// the stimulus, a negedge monitor pops them on each AXI handshake.
module tb_rank_writeback;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [63:0] base_addr;
  logic [63:0] n_values;
  logic        in_valid;
  logic [63:0] in_data;
  logic        in_ready;
  logic        busy;
  logic        done;
  logic [15:0] err_count;

  rank_writeback_if axi ();

  rank_writeback #(
    .MAX_OUTSTANDING(4),
    .AWID(16'h0002)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .base_addr(base_addr),
    .n_values(n_values),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_ready(in_ready),
    .axi(axi),
    .busy(busy),
    .done(done),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [63:0]  aw_q[$];
  logic [511:0] wd_q[$];
  logic [63:0]  ws_q[$];

  int aw_hs_cnt = 0;
  int w_hs_cnt = 0;
  int b_sent = 0;
  int aw_valid_cycles = 0;
  int aw_block = 0;
  bit b_en = 1'b1;
  logic [1:0] b_code = 2'b00;

  task automatic chk(input string name,
                     input logic [511:0] act,
                     input logic [511:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: compares every AW/W handshake against the scoreboard.
  always @(negedge clk) begin
    if (axi.awvalid) aw_valid_cycles++;
    if (axi.awvalid && axi.awready) begin
      aw_hs_cnt++;
      chk("aw_expected", aw_q.size() != 0, 1);
      if (aw_q.size() != 0) begin
        chk("awaddr", axi.awaddr, aw_q.pop_front());
        chk("awid", axi.awid, 16'h0002);
        chk("awlen", axi.awlen, 8'd0);
        chk("awsize", axi.awsize, 3'b110);
      end
    end
    if (axi.wvalid && axi.wready) begin
      w_hs_cnt++;
      chk("w_expected", wd_q.size() != 0, 1);
      if (wd_q.size() != 0) begin
        chk("wdata", axi.wdata, wd_q.pop_front());
        chk("wstrb", axi.wstrb, ws_q.pop_front());
        chk("wlast", axi.wlast, 1'b1);
      end
    end
  end

  // Slave model: AW stall counted while awvalid is high; one B per AW.
  initial begin
    axi.awready = 1'b0;
    axi.wready  = 1'b1;
    axi.bvalid  = 1'b0;
    axi.bresp   = 2'b00;
    forever begin
      @(posedge clk);
      #1;
      axi.awready = (aw_block == 0);
      if (axi.awvalid && aw_block > 0) aw_block--;
      if (b_en && (aw_hs_cnt - b_sent) > 0) begin
        axi.bvalid = 1'b1;
        axi.bresp  = b_code;
        b_sent++;
      end else begin
        axi.bvalid = 1'b0;
        axi.bresp  = 2'b00;
      end
    end
  end

  task automatic pulse_start(input logic [63:0] b,
                             input logic [63:0] n);
    @(posedge clk);
    #1;
    start     = 1'b1;
    base_addr = b;
    n_values  = n;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic feed(input logic [63:0] first, input int n);
    bit ok;
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = first + 64'(i);
      ok = 1'b0;
      for (int c = 0; c < 400; c++) begin
        @(negedge clk);
        if (in_ready) begin
          ok = 1'b1;
          break;
        end
      end
      if (!ok) begin
        chk("feed_ready", ok, 1);
        in_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    chk({name, "_done"}, seen, 1);
    if (seen) begin
      @(negedge clk);
      chk({name, "_done_pulse"}, done, 0);
      chk({name, "_busy_low"}, busy, 0);
    end
  endtask

  initial begin
    int a0;
    int v0;
    bit fed;
    bit seen;
    logic [15:0]  exp_err;
    logic [511:0] d;

    rst       = 1'b1;
    start     = 1'b0;
    base_addr = '0;
    n_values  = '0;
    in_valid  = 1'b0;
    in_data   = '0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_bready", axi.bready, 0);
    chk("rst_awvalid", axi.awvalid, 0);
    chk("rst_done", done, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_bready", axi.bready, 1);
    chk("post_busy", busy, 0);
    chk("post_in_ready", in_ready, 0);
    chk("post_wvalid", axi.wvalid, 0);
    chk("post_err", err_count, 0);
    chk("post_wdata", axi.wdata, 0);
    chk("post_awaddr", axi.awaddr, 0);

    // Single full beat
    aw_q.push_back(64'h1000);
    wd_q.push_back({64'd1, 64'd2, 64'd3, 64'd4,
                    64'd5, 64'd6, 64'd7, 64'd8});
    ws_q.push_back(64'hFFFF_FFFF_FFFF_FFFF);
    a0 = aw_hs_cnt;
    pulse_start(64'h1000, 64'd8);
    chk("t042_busy", busy, 1);
    chk("t042_in_ready", in_ready, 1);
    feed(64'd1, 8);
    wait_done("t042", 100);
    chk("t042_aw_count", aw_hs_cnt - a0, 1);

    // Partial second beat, low address bits masked, error responses
    b_code = 2'b10;
    aw_q.push_back(64'h2000);
    wd_q.push_back({64'd11, 64'd12, 64'd13, 64'd14,
                    64'd15, 64'd16, 64'd17, 64'd18});
    ws_q.push_back(64'hFFFF_FFFF_FFFF_FFFF);
    aw_q.push_back(64'h2040);
    wd_q.push_back({64'd19, 64'd20, 384'd0});
    ws_q.push_back(64'hFFFF_0000_0000_0000);
    pulse_start(64'h2010, 64'd10);
    feed(64'd11, 10);
    wait_done("t043", 200);
    b_code = 2'b00;
`ifdef RANK_WB_ERRCNT_EN
    exp_err = 16'd2;
`else
    exp_err = 16'd0;
`endif
    chk("t043_err_count", err_count, exp_err);

    // Empty job: done one cycle after start, no AXI traffic
    a0 = aw_hs_cnt;
    v0 = aw_valid_cycles;
    @(posedge clk);
    #1;
    start     = 1'b1;
    base_addr = 64'h3000;
    n_values  = 64'd0;
    @(negedge clk);
    chk("t044_done_early", done, 0);
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    chk("t044_done", done, 1);
    chk("t044_err_cleared", err_count, 0);
    @(negedge clk);
    chk("t044_done_pulse", done, 0);
    chk("t044_awvalid_cycles", aw_valid_cycles - v0, 0);
    chk("t044_aw_count", aw_hs_cnt - a0, 0);

    // Outstanding limit with B withheld
    b_en = 1'b0;
    for (int b = 0; b < 6; b++) begin
      aw_q.push_back(64'h4000 + 64'(64 * b));
      d = '0;
      for (int j = 0; j < 8; j++)
        d[511-64*j -: 64] = 64'h100 + 64'(8 * b + j);
      wd_q.push_back(d);
      ws_q.push_back(64'hFFFF_FFFF_FFFF_FFFF);
    end
    a0 = aw_hs_cnt;
    fed = 1'b0;
    pulse_start(64'h4000, 64'd48);
    fork
      begin
        feed(64'h100, 48);
        fed = 1'b1;
      end
    join_none
    repeat (80) @(negedge clk);
    chk("t045_aw_limit", aw_hs_cnt - a0, 4);
    chk("t045_awvalid_low", axi.awvalid, 0);
    b_en = 1'b1;
    wait_done("t045", 600);
    chk("t045_fed", fed, 1);
    chk("t045_aw_total", aw_hs_cnt - a0, 6);

    // AW stalled, W accepted at once
    aw_block = 5;
    aw_q.push_back(64'h8000);
    wd_q.push_back({64'hA0, 64'hA1, 64'hA2, 64'hA3,
                    64'hA4, 64'hA5, 64'hA6, 64'hA7});
    ws_q.push_back(64'hFFFF_FFFF_FFFF_FFFF);
    pulse_start(64'h8000, 64'd8);
    fork
      feed(64'hA0, 8);
    join_none
    seen = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (axi.wvalid) begin
        seen = 1'b1;
        break;
      end
    end
    chk("t046_wvalid_seen", seen, 1);
    chk("t046_awvalid_with_w", axi.awvalid, 1);
    chk("t046_awready_low", axi.awready, 0);
    @(negedge clk);
    chk("t046_wvalid_drop", axi.wvalid, 0);
    chk("t046_awvalid_hold", axi.awvalid, 1);
    repeat (3) @(negedge clk);
    chk("t046_awvalid_hold5", axi.awvalid, 1);
    repeat (2) @(negedge clk);
    chk("t046_awvalid_drop", axi.awvalid, 0);
    wait_done("t046", 100);

    chk("sb_aw_empty", aw_q.size(), 0);
    chk("sb_w_empty", wd_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
